// File: rtl/reg_wb_ctrl.sv
// Writeback controller: buffers register-write requests in an in-order FIFO and
// drains one per cycle onto the register file write port, with hold, flush and hazard lookup.
module reg_wb_ctrl #(
  parameter int pw    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [pw-1:0]              req_addr,
  input  logic [7:0]                 req_data,
  input  logic                       hold,
  input  logic                       flush,
  input  logic [pw-1:0]              lk_addr,
  output logic                       lk_pend,
  output logic                       wr_en,
  output logic [pw:0]                wr_addr,
  output logic [7:0]                 dat_out,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [pw-1:0] addr;
    logic [7:0]    data;
  } wb_ent_t;

  wb_ent_t         mem [DEPTH];
  wb_ent_t         head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [DEPTH-1:0] slot_hit;

  assign req_ready = (count != CW'(DEPTH)) & ~flush;
  assign push      = req_valid & req_ready;
  assign pop       = ~hold & ~flush & (count != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      dat_out <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        wr_en   <= 1'b1;
        wr_addr <= {1'b0, head.addr};
        dat_out <= head.data;
      end else begin
        wr_en   <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: req_addr, data: req_data};
  end

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] ofs;
    assign ofs         = AW'(i) - rd_ptr;
    assign slot_hit[i] = ({1'b0, ofs} < count) && (mem[i].addr == lk_addr);
  end

  assign lk_pend = (|slot_hit) | (wr_en & (wr_addr[pw-1:0] == lk_addr));

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: a reference model queues expected writes on acceptance,
// a negedge monitor pops and compares them whenever the DUT issues a write.
module tb_reg_wb_ctrl;
  localparam int PW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [PW-1:0] req_addr = '0;
  logic [7:0]    req_data = '0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] lk_addr = '0;
  logic          lk_pend;
  logic          wr_en;
  logic [PW:0]   wr_addr;
  logic [7:0]    dat_out;
  logic [CW-1:0] count;

  reg_wb_ctrl #(.pw(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold), .flush(flush),
    .lk_addr(lk_addr), .lk_pend(lk_pend), .wr_en(wr_en), .wr_addr(wr_addr),
    .dat_out(dat_out), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct { logic [PW-1:0] a; logic [7:0] d; } ent_t;
  ent_t          fq[$];      // model of FIFO contents
  ent_t          exp_out[$]; // issued writes awaiting the monitor
  int            mcount = 0;
  bit            exp_wr = 0;
  logic [PW-1:0] last_a = '0;

  // Reference model, evaluated on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete(); exp_out.delete(); mcount = 0; exp_wr = 0;
    end else begin
      bit   acc, pp;
      ent_t e;
      acc = req_valid && (mcount != DEPTH) && !flush;
      pp  = !hold && !flush && (mcount != 0);
      if (flush) begin
        fq.delete(); mcount = 0; exp_wr = 0;
      end else begin
        exp_wr = pp;
        if (pp) begin
          e = fq.pop_front();
          exp_out.push_back(e);
          last_a = e.a;
        end
        if (acc) begin
          e.a = req_addr; e.d = req_data;
          fq.push_back(e);
        end
        mcount = mcount + int'(acc) - int'(pp);
      end
    end
  end

  function automatic bit model_pend(input logic [PW-1:0] a);
    bit p = exp_wr && (last_a == a);
    foreach (fq[i]) if (fq[i].a == a) p = 1;
    return p;
  endfunction

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      ent_t e;
      chk("wr_en", int'(wr_en), int'(exp_wr));
      if (wr_en) begin
        if (exp_out.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_out.pop_front();
          chk("wr_addr", int'(wr_addr), int'({1'b0, e.a}));
          chk("dat_out", int'(dat_out), int'(e.d));
        end
      end else if (exp_out.size() != 0) begin
        chk("missing_write", exp_out.size(), 0);
        exp_out.delete();
      end
      chk("count", int'(count), mcount);
      chk("req_ready", int'(req_ready), int'((mcount != DEPTH) && !flush));
      chk("lk_pend", int'(lk_pend), int'(model_pend(lk_addr)));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input int a, input int d);
    req_valid = v; req_addr = PW'(a); req_data = 8'(d);
  endtask

  initial begin
    #12;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_dat_out", int'(dat_out), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_lk_pend", int'(lk_pend), 0);
    rst_n = 1'b1;

    // 1: single write, two-edge latency
    tick();
    drive(1, 3, 8'hA5); tick();
    drive(0, 0, 0);
    chk("t1_count_after_push", int'(count), 1);
    chk("t1_no_bypass", int'(wr_en), 0);
    tick();
    chk("t1_wr_en", int'(wr_en), 1);
    chk("t1_wr_addr", int'(wr_addr), 3);
    chk("t1_dat_out", int'(dat_out), 8'hA5);
    tick();
    chk("t1_wr_en_drop", int'(wr_en), 0);
    chk("t1_count_zero", int'(count), 0);

    // 2: fill under hold, refuse fifth, drain in order
    hold = 1;
    for (int i = 0; i < 4; i++) begin drive(1, i, 8'h10 + i); tick(); end
    chk("t2_count_full", int'(count), 4);
    chk("t2_ready_full", int'(req_ready), 0);
    drive(1, 15, 8'hFF); tick();
    drive(0, 0, 0);
    chk("t2_refused", int'(count), 4);
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_pulse", int'(wr_en), 1);
      chk("t2_order_addr", int'(wr_addr), i);
      chk("t2_order_data", int'(dat_out), 8'h10 + i);
    end
    tick();
    chk("t2_done", int'(wr_en), 0);

    // 3: steady push+pop at count 2 across pointer wrap
    hold = 1;
    drive(1, 1, 8'h30); tick();
    drive(1, 2, 8'h31); tick();
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, i % 16, 8'h40 + i); tick();
      chk("t3_count_steady", int'(count), 2);
    end
    drive(0, 0, 0);
    repeat (4) tick();
    chk("t3_drained", int'(count), 0);

    // 4: hazard lookup
    hold = 1;
    drive(1, 5, 8'h55); tick();
    drive(1, 9, 8'h99); tick();
    drive(0, 0, 0);
    lk_addr = 9; #1 chk("t4_pend9", int'(lk_pend), 1);
    lk_addr = 7; #1 chk("t4_pend7", int'(lk_pend), 0);
    lk_addr = 5; #1 chk("t4_pend5", int'(lk_pend), 1);
    lk_addr = 9;
    hold = 0;
    tick(); tick();
    chk("t4_pend9_outstage", int'(lk_pend), 1);
    tick();
    chk("t4_pend9_drained", int'(lk_pend), 0);

    // 5: flush with a simultaneous request
    hold = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 6 + i, 8'h60 + i); tick(); end
    chk("t5_count3", int'(count), 3);
    flush = 1; drive(1, 12, 8'hCC); tick();
    flush = 0; drive(0, 0, 0);
    chk("t5_count_flushed", int'(count), 0);
    chk("t5_wr_en", int'(wr_en), 0);
    hold = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_write", int'(wr_en), 0);
    end

    // 6: async reset mid-drain
    hold = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 1 + i, 8'h70 + i); tick(); end
    drive(0, 0, 0);
    hold = 0; tick();
    chk("t6_draining", int'(wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_wr_en", int'(wr_en), 0);
    chk("t6_async_count", int'(count), 0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_quiet", int'(wr_en), 0);
    end
    drive(1, 14, 8'hE1); tick();
    drive(0, 0, 0); tick();
    chk("t6_new_write_addr", int'(wr_addr), 14);
    chk("t6_new_write_data", int'(dat_out), 8'hE1);
    repeat (3) tick();
    chk("sb_empty", exp_out.size() + fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
